all_things_led_blinker: RTL and testbench

//   Downstream stage of the single-bit LED PIO: takes its out_port as led_en and drives the board LED pin.

---
 rtl/all_things_led_blinker.sv | 150 +++++++++++++++
 tb/tb_all_things_led_blinker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/all_things_led_blinker.sv
// LED pin driver behind the LED PIO: steady or programmable blink, configured through
// a zero-wait Avalon-MM slave (CTRL, PERIOD, ON_TIME, STATUS).
module all_things_led_blinker #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        led_en,
    output logic        led_out
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(1000);
    localparam logic [CNT_W-1:0] ON_RST     = CNT_W'(500);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_e;

    logic [1:0]       ctrl_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] on_time_q;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_on_q, act_on_d;
    logic             led_q, led_d;

    logic             wr_en;
    logic             mode;
    logic             inv;
    logic             tick;
    logic [CNT_W-1:0] phase_inc;
    logic [CNT_W-1:0] load_period;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign mode         = ctrl_q[0];
    assign inv          = ctrl_q[1];
    assign tick         = (presc_q == PRE_MAX);
    assign phase_inc    = CNT_W'(phase_q + 1'b1);
    assign load_period  = (period_q == '0) ? CNT_W'(1) : period_q;
    assign unused_wdata = &{1'b0, writedata[31:CNT_W]};

    // Configuration registers; STATUS is read-only so address 3 writes are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= 2'b00;
            period_q  <= PERIOD_RST;
            on_time_q <= ON_RST;
        end else if (wr_en) begin
            case (address)
                2'd0:    ctrl_q    <= writedata[1:0];
                2'd1:    period_q  <= writedata[CNT_W-1:0];
                2'd2:    on_time_q <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {30'd0, ctrl_q};
            2'd1:    readdata = 32'(period_q);
            2'd2:    readdata = 32'(on_time_q);
            default: readdata = {30'd0, (state_q == S_ON), led_q};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            phase_q      <= '0;
            act_period_q <= '0;
            act_on_q     <= '0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            act_period_q <= act_period_d;
            act_on_q     <= act_on_d;
            led_q        <= led_d;
        end
    end

    // Blink FSM; a dropped enable or steady mode overrides any tick or wrap
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        phase_d      = phase_q;
        act_period_d = act_period_q;
        act_on_d     = act_on_q;

        if (!mode || !led_en) begin
            state_d = S_IDLE;
            presc_d = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    act_period_d = load_period;
                    act_on_d     = on_time_q;
                    phase_d      = '0;
                    presc_d      = '0;
                    state_d      = (on_time_q == '0) ? S_OFF : S_ON;
                end
                S_ON, S_OFF: begin
                    presc_d = tick ? '0 : PRE_W'(presc_q + 1'b1);
                    if (tick) begin
                        if (phase_inc == act_period_q) begin
                            act_period_d = load_period;
                            act_on_d     = on_time_q;
                            phase_d      = '0;
                            state_d      = (on_time_q == '0) ? S_OFF : S_ON;
                        end else begin
                            phase_d = phase_inc;
                            if (state_q == S_ON && phase_inc == act_on_q) begin
                                state_d = S_OFF;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    phase_d = '0;
                end
            endcase
        end

        led_d = mode ? ((state_d == S_ON) ^ inv) : (led_en ^ inv);
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_all_things_led_blinker.sv
// Directed bench for all_things_led_blinker with PRESCALE=4; expected values go through
// a scoreboard queue and are checked with immediate assertions.
module tb_all_things_led_blinker;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        led_en;
    logic        led_out;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    all_things_led_blinker #(.PRESCALE(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_en     (led_en),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total = total + 1;
        assert (obs === e) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    endtask

    task automatic chk_led(input string tag, input logic exp);
        push_exp(tag, {31'd0, exp});
        check_pop({31'd0, led_out});
    endtask

    task automatic cyc(input string tag, input logic exp);
        push_exp(tag, {31'd0, exp});
        @(posedge clk);
        #1;
        check_pop({31'd0, led_out});
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        address = addr;
        push_exp(tag, exp);
        #1;
        check_pop(readdata);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data, input logic exp_led);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        push_exp("write_cycle_led", {31'd0, exp_led});
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_pop({31'd0, led_out});
    endtask

    initial begin
        logic       e;
        logic       prev;
        logic [7:0] pat;

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        led_en     = 1'b0;

        cyc("reset_led", 1'b0);
        cyc("reset_led", 1'b0);
        reset = 1'b0;
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_period", 2'd1, 32'd1000);
        rd("rst_on", 2'd2, 32'd500);
        rd("rst_status", 2'd3, 32'd0);
        cyc("idle_led", 1'b0);

        // field masking and read-only status
        wr(2'd1, 32'hABCD_0004, 1'b0);
        rd("period_mask", 2'd1, 32'd4);
        wr(2'd3, 32'hFFFF_FFFF, 1'b0);
        rd("status_ro", 2'd3, 32'd0);
        wr(2'd2, 32'd2, 1'b0);
        rd("on_rd", 2'd2, 32'd2);
        wr(2'd0, 32'hFFFF_FFFD, 1'b0);
        rd("ctrl_mask", 2'd0, 32'd1);

        // PERIOD=4 ON=2: 8 clks on, 8 off
        led_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            e = ((i % 16) < 8);
            cyc("blink", e);
            rd("blink_status", 2'd3, {30'd0, e, e});
        end
        led_en = 1'b0;
        cyc("blink_drop", 1'b0);

        // ON=0 -> always off
        wr(2'd2, 32'd0, 1'b0);
        led_en = 1'b1;
        repeat (20) cyc("on_zero", 1'b0);
        rd("on_zero_status", 2'd3, 32'd0);
        led_en = 1'b0;
        cyc("on_zero_drop", 1'b0);

        // ON=5 > PERIOD=4 -> always on
        wr(2'd2, 32'd5, 1'b0);
        led_en = 1'b1;
        repeat (40) cyc("on_gt_period", 1'b1);
        led_en = 1'b0;
        cyc("on_gt_drop", 1'b0);

        // PERIOD=0 acts as 1, ON=1 -> always on
        wr(2'd1, 32'd0, 1'b0);
        wr(2'd2, 32'd1, 1'b0);
        rd("period_zero_rd", 2'd1, 32'd0);
        led_en = 1'b1;
        repeat (20) cyc("period_zero", 1'b1);
        led_en = 1'b0;
        cyc("period_zero_drop", 1'b0);

        // PERIOD written mid-ON only affects the next period
        wr(2'd1, 32'd4, 1'b0);
        wr(2'd2, 32'd2, 1'b0);
        led_en = 1'b1;
        repeat (3) cyc("midwr_on1", 1'b1);
        wr(2'd1, 32'd8, 1'b1);
        repeat (4)  cyc("midwr_on1", 1'b1);
        repeat (8)  cyc("midwr_off1", 1'b0);
        repeat (8)  cyc("midwr_on2", 1'b1);
        repeat (24) cyc("midwr_off2", 1'b0);
        repeat (2)  cyc("midwr_on3", 1'b1);

        // drop enable mid-ON, then reassert for a fresh ON phase
        led_en = 1'b0;
        cyc("drop_mid_on", 1'b0);
        repeat (2) cyc("dropped", 1'b0);
        led_en = 1'b1;
        repeat (8) cyc("reassert_on", 1'b1);
        repeat (4) cyc("reassert_off", 1'b0);

        // inverted output
        led_en = 1'b0;
        cyc("pre_inv", 1'b0);
        wr(2'd1, 32'd4, 1'b0);
        wr(2'd0, 32'd3, 1'b0);
        cyc("inv_idle", 1'b1);
        rd("inv_ctrl", 2'd0, 32'd3);
        led_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            e = ((i % 16) >= 8);
            cyc("inv_blink", e);
            rd("inv_status", 2'd3, {30'd0, ~e, e});
        end

        // steady mode with one clock of lag
        led_en = 1'b0;
        cyc("inv_drop", 1'b1);
        wr(2'd0, 32'd0, 1'b1);
        cyc("steady_start", 1'b0);
        pat  = 8'b1011_0010;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            led_en = pat[i];
            #1;
            chk_led("steady_hold", prev);
            cyc("steady", pat[i]);
            prev = pat[i];
        end

        // async reset while blinking
        led_en = 1'b1;
        cyc("pre_rst_steady", 1'b1);
        wr(2'd0, 32'd1, 1'b1);
        repeat (3) cyc("pre_rst_blink", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_led("async_rst_led", 1'b0);
        rd("async_rst_ctrl", 2'd0, 32'd0);
        rd("async_rst_period", 2'd1, 32'd1000);
        rd("async_rst_on", 2'd2, 32'd500);
        rd("async_rst_status", 2'd3, 32'd0);
        reset = 1'b0;
        cyc("post_rst_steady", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
